fetch_insn_queue: RTL and testbench
===================================

Name: fetch_insn_queue

Overview:
Circular instruction buffer that sits directly downstream of the fetch stage and decouples fetch from pre-decode/decode stalls. Each cycle it accepts a group of up to FETCH_WIDTH fetched instructions, each with its PC and branch-prediction bit. Each cycle it presents up to DECODE_WIDTH of the oldest entries in program order. A flush from the recovery logic empties the queue in one cycle.

Parameters:
FETCH_WIDTH, 2, max instructions enqueued per cycle
DECODE_WIDTH, 2, max instructions presented/dequeued per cycle
DEPTH, 8, number of entries; power of two, >= FETCH_WIDTH + DECODE_WIDTH
PC_WIDTH, 32, PC width
INSN_WIDTH, 32, instruction word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
flush  in  1  discard all contents
enq_valid  in  FETCH_WIDTH  per-lane valid; valid lanes form a prefix starting at lane 0
enq_pc  in  FETCH_WIDTH*PC_WIDTH  lane PCs; lane i occupies bits [i*PC_WIDTH +: PC_WIDTH]
enq_insn  in  FETCH_WIDTH*INSN_WIDTH  lane instruction words
enq_pred_taken  in  FETCH_WIDTH  lane branch predicted taken
enq_ready  out  1  queue can accept a full FETCH_WIDTH group this cycle
deq_valid  out  DECODE_WIDTH  lane i holds the (i+1)-th oldest entry
deq_pc  out  DECODE_WIDTH*PC_WIDTH  head entry PCs
deq_insn  out  DECODE_WIDTH*INSN_WIDTH  head entry instruction words
deq_pred_taken  out  DECODE_WIDTH  head entry predictions
deq_count  in  $clog2(DECODE_WIDTH+1)  number of head entries consumed this cycle
count  out  $clog2(DEPTH+1)  current occupancy
empty  out  1  count == 0

Behaviour:
- Reset (rst low) clears head, tail and count asynchronously. Reset output values: enq_ready=1, deq_valid=0, deq_pc/deq_insn/deq_pred_taken=0, count=0, empty=1. Storage array is not reset.
- Storage is DEPTH entries of {pc, insn, pred_taken}.
- head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is held separately so the full (count==DEPTH) and empty (count==0) states are unambiguous.
- enq_ready is combinational from registered count only: enq_ready = (count <= DEPTH-FETCH_WIDTH). No credit is given for a same-cycle dequeue.
- Enqueue fires when enq_ready & |enq_valid & !flush.
  - Write n = popcount(enq_valid) lanes to tail, tail+1, ... tail+n-1 (mod DEPTH); tail += n.
  - Enqueue is all-or-nothing per group. With enq_ready=0 the group is ignored and upstream must hold it.
- Dequeue outputs are combinational from registered state; there is no same-cycle enqueue bypass.
  - An entry written at cycle t is visible on deq_* at cycle t+1 at the earliest.
  - deq_valid[i] = (i < count). Payload lanes with deq_valid=0 are driven to 0.
- Dequeue: head += k and count -= k at the clock edge, where k = min(deq_count, count).
  - deq_count > count is illegal: flag with an assertion; RTL clamps.
- Simultaneous enqueue and dequeue: count_next = count + n - k. Both pointers update independently.
- Flush has top priority. Next cycle: head=tail=0 and count=0. Enqueue and dequeue in the flush cycle are discarded.
- A non-prefix enq_valid pattern (e.g. 2'b10) is illegal and flagged with an assertion.
- Reset asserted mid-operation drops all contents immediately. Outputs take reset values while rst is low. Operation resumes at the first clock edge after rst goes high.
- No other hidden state; behaviour is fully defined by {head, tail, count, storage}.

Decomposition:
- Package FetchQueueTypes holds:
  - FetchQueueEntry struct {pc, insn, pred_taken}
  - FetchQueueIndexPath ($clog2(DEPTH) bits)
  - FetchQueueCountPath ($clog2(DEPTH+1) bits)
  - default FETCH_QUEUE_DEPTH constant
- One natural sub-module: fetch_queue_ram, a DEPTH-entry register array with FETCH_WIDTH write ports and DECODE_WIDTH asynchronous read ports.
- Pointer/count logic and output gating stay in fetch_insn_queue.

Test Plan:
1. Reset, then enq_valid=2'b11 with PCs 0x1000/0x1004 and deq_count=0. Required: deq_valid=2'b00 in the same cycle; next cycle deq_valid=2'b11, deq_pc lanes = 0x1000/0x1004, count=2.
2. Enqueue 2'b11 for 3 cycles with deq_count=0 (count=6), then a 4th group. Required: enq_ready=1 at count=6; count=8 after that group; enq_ready=0 and empty=0 at count=8. A group presented while full leaves count at 8.
3. Reach full, hold enqueue, set deq_count=2. Required: enq_ready stays 0 that cycle (no same-cycle credit); next cycle count=6 and enq_ready=1; head entries advance by 2 in order.
4. Wrap-around: run 20 cycles of alternating enqueue 2'b01/2'b11 and deq_count=1/2. Required: dequeued PC sequence exactly equals enqueued sequence across the pointer wrap at index 7->0.
5. With count=5, assert flush together with enq_valid=2'b11 and deq_count=2. Required: next cycle count=0, empty=1, deq_valid=0; a following enqueue appears at deq lane 0.
6. With count=3, drop rst low mid-cycle. Required: deq_valid=0, count=0 and enq_ready=1 immediately, without waiting for a clock edge; the queue stays empty after rst is released.

Source files
------------

// File: rtl/fetch_insn_queue_pkg.sv
// Shared types for the fetch instruction queue.
//   fq_entry_t  : one stored slot {pc, insn, pred_taken}
//   fq_index_t  : head/tail pointer for the default depth
//   fq_count_t  : occupancy counter for the default depth
package fetch_insn_queue_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 8;
  localparam int unsigned FQ_PC_WIDTH       = 32;
  localparam int unsigned FQ_INSN_WIDTH     = 32;

  typedef logic [$clog2(FETCH_QUEUE_DEPTH)-1:0]   fq_index_t;
  typedef logic [$clog2(FETCH_QUEUE_DEPTH+1)-1:0] fq_count_t;

  typedef struct packed {
    logic [FQ_PC_WIDTH-1:0]   pc;
    logic [FQ_INSN_WIDTH-1:0] insn;
    logic                     pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Register array backing the fetch queue.
//   clk      : write clock
//   wr_en    : per-port write enable
//   wr_addr  : per-port write index, port i at [i*IDX_W +: IDX_W]
//   wr_data  : per-port packed fq_entry_t
//   rd_addr  : per-port read index (asynchronous read)
//   rd_data  : per-port packed fq_entry_t
module fetch_queue_ram
  import fetch_insn_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_QUEUE_DEPTH,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                                   clk,
  input  logic [NUM_WR-1:0]                      wr_en,
  input  logic [NUM_WR*$clog2(DEPTH)-1:0]        wr_addr,
  input  logic [NUM_WR*$bits(fq_entry_t)-1:0]    wr_data,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]        rd_addr,
  output logic [NUM_RD*$bits(fq_entry_t)-1:0]    rd_data
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = $bits(fq_entry_t);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  // Write ports; the queue never targets the same slot from two lanes.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) begin
        mem_d[wr_addr[i*IDX_W +: IDX_W]] = fq_entry_t'(wr_data[i*ENTRY_W +: ENTRY_W]);
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*ENTRY_W +: ENTRY_W] = mem_q[rd_addr[i*IDX_W +: IDX_W]];
    end
  end

endmodule

// File: rtl/fetch_insn_queue.sv
// Circular instruction queue between fetch and decode.
//   clk, rst (async, active-low)
//   flush                      : empty the queue next cycle
//   enq_valid/pc/insn/pred     : incoming group, valid lanes form a prefix
//   enq_ready                  : a full FETCH_WIDTH group fits (from registered count)
//   deq_valid/pc/insn/pred     : oldest DECODE_WIDTH entries, invalid lanes zeroed
//   deq_count                  : entries consumed this cycle (clamped to count)
//   count, empty               : occupancy
module fetch_insn_queue
  import fetch_insn_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = FETCH_QUEUE_DEPTH,
  parameter int unsigned PC_WIDTH     = FQ_PC_WIDTH,
  parameter int unsigned INSN_WIDTH   = FQ_INSN_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0]                 enq_valid,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]        enq_pc,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0]      enq_insn,
  input  logic [FETCH_WIDTH-1:0]                 enq_pred_taken,
  output logic                                   enq_ready,
  output logic [DECODE_WIDTH-1:0]                deq_valid,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0]       deq_pc,
  output logic [DECODE_WIDTH*INSN_WIDTH-1:0]     deq_insn,
  output logic [DECODE_WIDTH-1:0]                deq_pred_taken,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]      deq_count,
  output logic [$clog2(DEPTH+1)-1:0]             count,
  output logic                                   empty
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = $bits(fq_entry_t);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] enq_num;
  logic [CNT_W-1:0] deq_num;
  logic             enq_fire;

  logic [FETCH_WIDTH-1:0]          wr_en;
  logic [FETCH_WIDTH*IDX_W-1:0]    wr_addr;
  logic [FETCH_WIDTH*ENTRY_W-1:0]  wr_data;
  logic [DECODE_WIDTH*IDX_W-1:0]   rd_addr;
  logic [DECODE_WIDTH*ENTRY_W-1:0] rd_data;

  // No credit for a same-cycle dequeue: only the registered count matters.
  assign enq_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign enq_fire  = enq_ready & (|enq_valid) & ~flush;
  assign count     = count_q;
  assign empty     = (count_q == '0);

  // Lanes in the group and entries actually consumed.
  always_comb begin
    enq_num = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_num = enq_num + CNT_W'(enq_valid[i]);
    end
    deq_num = CNT_W'(deq_count);
    if (deq_num > count_q) begin
      deq_num = count_q;
    end
  end

  // Pointer and occupancy update; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + IDX_W'(enq_num);
      end
      head_d  = head_q + IDX_W'(deq_num);
      count_d = count_q + (enq_fire ? enq_num : '0) - deq_num;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write and read port addressing.
  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_en[i]                       = enq_fire & enq_valid[i];
      wr_addr[i*IDX_W +: IDX_W]      = tail_q + IDX_W'(i);
      wr_data[i*ENTRY_W +: ENTRY_W]  = {enq_pc[i*PC_WIDTH +: PC_WIDTH],
                                        enq_insn[i*INSN_WIDTH +: INSN_WIDTH],
                                        enq_pred_taken[i]};
    end
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rd_addr[i*IDX_W +: IDX_W] = head_q + IDX_W'(i);
    end
  end

  fetch_queue_ram #(
    .DEPTH  (DEPTH),
    .NUM_WR (FETCH_WIDTH),
    .NUM_RD (DECODE_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Head lanes, zeroed beyond current occupancy.
  always_comb begin
    fq_entry_t ent;
    deq_valid      = '0;
    deq_pc         = '0;
    deq_insn       = '0;
    deq_pred_taken = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      ent          = fq_entry_t'(rd_data[i*ENTRY_W +: ENTRY_W]);
      deq_valid[i] = (CNT_W'(i) < count_q);
      if (deq_valid[i]) begin
        deq_pc[i*PC_WIDTH +: PC_WIDTH]       = ent.pc;
        deq_insn[i*INSN_WIDTH +: INSN_WIDTH] = ent.insn;
        deq_pred_taken[i]                    = ent.pred_taken;
      end
    end
  end

  a_deq_count_legal : assert property (@(posedge clk) disable iff (!rst)
    CNT_W'(deq_count) <= count_q)
    else $error("fetch_insn_queue: deq_count exceeds occupancy");

  a_enq_valid_prefix : assert property (@(posedge clk) disable iff (!rst)
    ((enq_valid + FETCH_WIDTH'(1)) & enq_valid) == '0)
    else $error("fetch_insn_queue: enq_valid is not a prefix");

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Testbench for fetch_insn_queue: directed table, wrap sequence, random, reset.
module tb_fetch_insn_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [63:0] enq_pc;
  logic [63:0] enq_insn;
  logic [1:0]  enq_pred_taken;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_pc;
  logic [63:0] deq_insn;
  logic [1:0]  deq_pred_taken;
  logic [1:0]  deq_count;
  logic [3:0]  count;
  logic        empty;

  fetch_insn_queue dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .enq_valid      (enq_valid),
    .enq_pc         (enq_pc),
    .enq_insn       (enq_insn),
    .enq_pred_taken (enq_pred_taken),
    .enq_ready      (enq_ready),
    .deq_valid      (deq_valid),
    .deq_pc         (deq_pc),
    .deq_insn       (deq_insn),
    .deq_pred_taken (deq_pred_taken),
    .deq_count      (deq_count),
    .count          (count),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pt;
  } ent_t;

  typedef struct {
    logic        fl;
    logic [1:0]  ev;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  dc;
    int          exp_cnt;
    logic        exp_rdy;
    logic [1:0]  exp_dv;
    logic [31:0] exp_pc0;
  } vec_t;

  ent_t        mq[$];
  logic [31:0] enq_log[$];
  logic [31:0] deq_log[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("enq_ready", 32'(enq_ready), 32'(sz <= 6));
    chk("empty", 32'(empty), 32'(sz == 0));
    for (int i = 0; i < 2; i++) begin
      logic v;
      v = (i < sz);
      chk($sformatf("deq_valid%0d", i), 32'(deq_valid[i]), 32'(v));
      chk($sformatf("deq_pc%0d", i), deq_pc[i*32 +: 32], v ? mq[i].pc : 32'h0);
      chk($sformatf("deq_insn%0d", i), deq_insn[i*32 +: 32], v ? mq[i].insn : 32'h0);
      chk($sformatf("deq_pred%0d", i), 32'(deq_pred_taken[i]), v ? 32'(mq[i].pt) : 32'h0);
    end
  endtask

  // One clock: drive, check, advance, update model. Entered and left at posedge+1.
  task automatic step(input logic fl, input logic [1:0] ev, input logic [31:0] p0,
                      input logic [31:0] p1, input logic [1:0] dc);
    logic [31:0] i0, i1;
    logic [1:0]  pt;
    int          k;
    bit          rdy;
    ent_t        e;
    i0 = $urandom;
    i1 = $urandom;
    pt = 2'($urandom);
    flush          = fl;
    enq_valid      = ev;
    enq_pc         = {p1, p0};
    enq_insn       = {i1, i0};
    enq_pred_taken = pt;
    deq_count      = dc;
    #1;
    check_outputs();
    k = int'(dc);
    if (k > mq.size()) k = mq.size();
    if (!fl) begin
      for (int j = 0; j < k; j++) deq_log.push_back(deq_pc[j*32 +: 32]);
    end
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      rdy = (mq.size() <= 6);
      for (int j = 0; j < k; j++) void'(mq.pop_front());
      if (rdy && ev[0]) begin
        e = '{pc: p0, insn: i0, pt: pt[0]};
        mq.push_back(e);
        enq_log.push_back(p0);
      end
      if (rdy && ev[1]) begin
        e = '{pc: p1, insn: i1, pt: pt[1]};
        mq.push_back(e);
        enq_log.push_back(p1);
      end
    end
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    logic [31:0] pcb;
    logic [1:0]  ev, dc;
    logic        fl;
    int          r, mx;

    tbl[0]  = '{1'b0, 2'b11, 32'h1000, 32'h1004, 2'd0, 0, 1'b1, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 2'b11, 32'h1008, 32'h100c, 2'd0, 2, 1'b1, 2'b11, 32'h1000};
    tbl[2]  = '{1'b0, 2'b11, 32'h1010, 32'h1014, 2'd0, 4, 1'b1, 2'b11, 32'h1000};
    tbl[3]  = '{1'b0, 2'b11, 32'h1018, 32'h101c, 2'd0, 6, 1'b1, 2'b11, 32'h1000};
    tbl[4]  = '{1'b0, 2'b11, 32'h1020, 32'h1024, 2'd0, 8, 1'b0, 2'b11, 32'h1000};
    tbl[5]  = '{1'b0, 2'b11, 32'h1020, 32'h1024, 2'd2, 8, 1'b0, 2'b11, 32'h1000};
    tbl[6]  = '{1'b0, 2'b11, 32'h1020, 32'h1024, 2'd0, 6, 1'b1, 2'b11, 32'h1008};
    tbl[7]  = '{1'b0, 2'b00, 32'h0,    32'h0,    2'd2, 8, 1'b0, 2'b11, 32'h1008};
    tbl[8]  = '{1'b0, 2'b00, 32'h0,    32'h0,    2'd1, 6, 1'b1, 2'b11, 32'h1010};
    tbl[9]  = '{1'b1, 2'b11, 32'h2000, 32'h2004, 2'd2, 5, 1'b1, 2'b11, 32'h1014};
    tbl[10] = '{1'b0, 2'b01, 32'h3000, 32'h0,    2'd0, 0, 1'b1, 2'b00, 32'h0};
    tbl[11] = '{1'b0, 2'b00, 32'h0,    32'h0,    2'd0, 1, 1'b1, 2'b01, 32'h3000};

    rst = 1'b0;
    flush = 1'b0;
    enq_valid = '0;
    enq_pc = '0;
    enq_insn = '0;
    enq_pred_taken = '0;
    deq_count = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Directed fill / full / no-credit / flush sequence.
    foreach (tbl[i]) begin
      chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("row%0d_ready", i), 32'(enq_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("row%0d_dvalid", i), 32'(deq_valid), 32'(tbl[i].exp_dv));
      chk($sformatf("row%0d_pc0", i), deq_pc[31:0], tbl[i].exp_pc0);
      step(tbl[i].fl, tbl[i].ev, tbl[i].p0, tbl[i].p1, tbl[i].dc);
    end

    // Wrap-around: program order preserved across index 7 -> 0.
    step(1'b1, 2'b00, 32'h0, 32'h0, 2'd0);
    enq_log.delete();
    deq_log.delete();
    pcb = 32'h4000;
    for (int c = 0; c < 20; c++) begin
      ev = (c % 2 == 0) ? 2'b01 : 2'b11;
      mx = (c % 2 == 0) ? 1 : 2;
      if (mx > mq.size()) mx = mq.size();
      step(1'b0, ev, pcb, pcb + 32'd4, 2'(mx));
      pcb = pcb + 32'd8;
    end
    chk("wrap_len", 32'(deq_log.size() + mq.size()), 32'(enq_log.size()));
    foreach (deq_log[i]) chk($sformatf("wrap_seq%0d", i), deq_log[i], enq_log[i]);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      r  = $urandom_range(0, 2);
      ev = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      mx = (mq.size() < 2) ? mq.size() : 2;
      dc = 2'($urandom_range(0, mx));
      fl = ($urandom_range(0, 19) == 0);
      step(fl, ev, $urandom, $urandom, dc);
    end

    // Asynchronous reset mid-cycle with three entries held.
    step(1'b1, 2'b00, 32'h0, 32'h0, 2'd0);
    step(1'b0, 2'b11, 32'h5000, 32'h5004, 2'd0);
    step(1'b0, 2'b01, 32'h5008, 32'h0, 2'd0);
    chk("pre_reset_count", 32'(count), 32'd3);
    enq_valid = 2'b00;
    deq_count = 2'd0;
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_dvalid", 32'(deq_valid), 32'd0);
    chk("async_rst_ready", 32'(enq_ready), 32'd1);
    chk("async_rst_empty", 32'(empty), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    step(1'b0, 2'b01, 32'h6000, 32'h0, 2'd0);
    chk("post_reset_pc0", deq_pc[31:0], 32'h6000);
    step(1'b0, 2'b00, 32'h0, 32'h0, 2'd1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
